// File: rtl/wb_writeback_unit_pkg.sv
// wb_pkg: shared widths, load funct3 encodings and FSM states for the writeback unit.
package wb_pkg;
   localparam int XLEN   = 64;
   localparam int REG_AW = 5;
   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LD   = 3'b011;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_LWU  = 3'b110;
   localparam logic [2:0] F3_RSVD = 3'b111;
   typedef enum logic {IDLE, WAIT_MEM} state_t;
endpackage

// File: rtl/wb_writeback_unit_if.sv
// wb_writeback_unit_if: MEM-stage input, load response and register-file write bundle.
// With WB_FWD_EN defined it also carries the combinational forwarding outputs.
interface wb_writeback_unit_if;
   import wb_pkg::*;
   logic              in_valid;
   logic              in_ready;
   logic [REG_AW-1:0] in_rd;
   logic              in_reg_write;
   logic              in_mem_to_reg;
   logic [2:0]        in_funct3;
   logic [XLEN-1:0]   in_alu_result;
   logic              mem_rsp_valid;
   logic [XLEN-1:0]   mem_rsp_data;
   logic              wb_reg_write;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              stall;
   logic              err;
`ifdef WB_FWD_EN
   logic              fwd_valid;
   logic [REG_AW-1:0] fwd_rd;
   logic [XLEN-1:0]   fwd_data;
`endif
   modport slave (
      input  in_valid, in_rd, in_reg_write, in_mem_to_reg, in_funct3, in_alu_result,
      input  mem_rsp_valid, mem_rsp_data,
`ifdef WB_FWD_EN
      output fwd_valid, fwd_rd, fwd_data,
`endif
      output in_ready, wb_reg_write, wb_rd, wb_data, stall, err
   );
   modport master (
      output in_valid, in_rd, in_reg_write, in_mem_to_reg, in_funct3, in_alu_result,
      output mem_rsp_valid, mem_rsp_data,
`ifdef WB_FWD_EN
      input  fwd_valid, fwd_rd, fwd_data,
`endif
      input  in_ready, wb_reg_write, wb_rd, wb_data, stall, err
   );
endinterface

// File: rtl/wb_writeback_unit_load_extract.sv
// wb_load_extract: selects and sign/zero-extends the addressed field of a load doubleword.
module wb_load_extract
   import wb_pkg::*;
(
   input  logic [XLEN-1:0] i_data,
   input  logic [2:0]      i_funct3,
   input  logic [2:0]      i_off,
   output logic [XLEN-1:0] o_value,
   output logic            o_illegal
);
   logic [7:0]  w_b;
   logic [15:0] w_h;
   logic [31:0] w_w;
   // offset bits below the access size are ignored, so misaligned addresses round down
   assign w_b = i_data[{i_off, 3'b000} +: 8];
   assign w_h = i_data[{i_off[2:1], 4'b0000} +: 16];
   assign w_w = i_data[{i_off[2], 5'b00000} +: 32];
   always_comb begin
      o_illegal = 1'b0;
      case (i_funct3)
         F3_LB:   o_value = {{(XLEN-8){w_b[7]}}, w_b};
         F3_LH:   o_value = {{(XLEN-16){w_h[15]}}, w_h};
         F3_LW:   o_value = {{(XLEN-32){w_w[31]}}, w_w};
         F3_LD:   o_value = i_data;
         F3_LBU:  o_value = {{(XLEN-8){1'b0}}, w_b};
         F3_LHU:  o_value = {{(XLEN-16){1'b0}}, w_h};
         F3_LWU:  o_value = {{(XLEN-32){1'b0}}, w_w};
         default: begin
            o_value   = '0;
            o_illegal = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: MEM/WB register and writeback stage with bounded load-response wait.
// Define WB_FWD_EN to expose next-edge writeback values (fwd_*) for EX bypass.
module wb_writeback_unit
   import wb_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input logic                clk,
   input logic                rst_n,
   wb_writeback_unit_if.slave bus
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   state_t            r_state, w_state_nxt;
   logic [REG_AW-1:0] r_rd, r_wb_rd, w_rd, w_wb_rd_nxt;
   logic [2:0]        r_f3, r_off, w_f3, w_off;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_wb_data, w_ext, w_wb_data_nxt;
   logic              r_we, r_wb_we, r_err;
   logic              w_idle, w_we, w_load, w_ill, w_retire, w_park, w_timeout, w_bad, w_wr;
   assign w_idle = r_state == IDLE;
   // in WAIT_MEM every field comes from the hold registers captured at acceptance
   assign w_rd   = w_idle ? bus.in_rd : r_rd;
   assign w_we   = w_idle ? bus.in_reg_write : r_we;
   assign w_f3   = w_idle ? bus.in_funct3 : r_f3;
   assign w_off  = w_idle ? bus.in_alu_result[2:0] : r_off;
   assign w_load = w_idle ? bus.in_mem_to_reg : 1'b1;
   wb_load_extract u_extract (
      .i_data    (bus.mem_rsp_data),
      .i_funct3  (w_f3),
      .i_off     (w_off),
      .o_value   (w_ext),
      .o_illegal (w_ill)
   );
   assign w_retire  = w_idle ? bus.in_valid & (!bus.in_mem_to_reg | bus.mem_rsp_valid) : bus.mem_rsp_valid;
   assign w_park    = w_idle & bus.in_valid & bus.in_mem_to_reg & !bus.mem_rsp_valid;
   assign w_timeout = !w_idle & !bus.mem_rsp_valid & (r_cnt == CW'(MEM_TIMEOUT - 1));
   assign w_bad     = w_retire & w_load & w_ill;
   assign w_wr      = w_retire & w_we & (w_rd != '0) & !w_bad;
   assign w_wb_rd_nxt   = w_retire ? w_rd : r_wb_rd;
   assign w_wb_data_nxt = !w_retire ? r_wb_data : w_load ? w_ext : bus.in_alu_result;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_nxt;
   always_comb begin
      w_state_nxt = r_state;
      if (w_park) w_state_nxt = WAIT_MEM;
      else if (!w_idle && (bus.mem_rsp_valid || w_timeout)) w_state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rd      <= '0;
         r_we      <= 1'b0;
         r_f3      <= '0;
         r_off     <= '0;
         r_cnt     <= '0;
         r_wb_we   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_park) begin
            r_rd  <= bus.in_rd;
            r_we  <= bus.in_reg_write;
            r_f3  <= bus.in_funct3;
            r_off <= bus.in_alu_result[2:0];
            r_cnt <= '0;
         end else if (!w_idle) r_cnt <= r_cnt + 1'b1;
         r_wb_we   <= w_wr;
         r_wb_rd   <= w_wb_rd_nxt;
         r_wb_data <= w_wb_data_nxt;
         r_err     <= r_err | w_bad | w_timeout;
      end
   assign bus.in_ready     = w_idle;
   assign bus.stall        = !w_idle;
   assign bus.wb_reg_write = r_wb_we;
   assign bus.wb_rd        = r_wb_rd;
   assign bus.wb_data      = r_wb_data;
   assign bus.err          = r_err;
`ifdef WB_FWD_EN
   assign bus.fwd_valid = w_wr;
   assign bus.fwd_rd    = w_wb_rd_nxt;
   assign bus.fwd_data  = w_wb_data_nxt;
`endif
endmodule
